slot_alloc_tracker: RTL and testbench

- Owns the free/busy state of RANGE dispatch slots (CU or warp slots) and the rotating preference pointer.
- Drives the availability vector and preference index into the external preferred-first selector, and consumes that selector's valid/id result.
- Issues registered slot grants to allocation requesters and frees slots on release.
- Sits between the CTA allocator front end and the selector/arbiter logic in the CTA scheduler.

---
 rtl/slot_alloc_tracker.sv | 162 ++++++++++++++++
 tb/tb_slot_alloc_tracker.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/slot_alloc_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : slot_alloc_tracker
//  Purpose  : Tracks free/busy state of RANGE dispatch slots and the rotating
//             preference pointer. Feeds an external preferred-first selector
//             (avail_o/prefer_o) and consumes its result (sel_valid_i /
//             sel_id_i) to turn allocation requests into registered grants.
//             Releases free slots; flush frees everything in one cycle.
//  Ports    : clk, rst_n            - clock, synchronous active-low reset
//             avail_o, prefer_o     - to selector (free vector, start index)
//             sel_valid_i, sel_id_i - from selector (chosen free slot)
//             alloc_valid_i/tag_i   - allocation request, alloc_ready_o accept
//             grant_valid/id/tag_o  - registered one-cycle grant
//             release_valid/id_i    - free a busy slot
//             flush_i               - free all slots, reset pointer
//             busy_cnt_o, full_o, empty_o, err_o - status, sticky error
//  Revision : 1.0 - initial release
// ============================================================================
module slot_alloc_tracker #(
    parameter int RANGE     = 8,
    parameter int ID_WIDTH  = 3,
    parameter int TAG_WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    output logic [RANGE-1:0]     avail_o,
    output logic [ID_WIDTH-1:0]  prefer_o,
    input  logic                 sel_valid_i,
    input  logic [ID_WIDTH-1:0]  sel_id_i,
    input  logic                 alloc_valid_i,
    input  logic [TAG_WIDTH-1:0] alloc_tag_i,
    output logic                 alloc_ready_o,
    output logic                 grant_valid_o,
    output logic [ID_WIDTH-1:0]  grant_id_o,
    output logic [TAG_WIDTH-1:0] grant_tag_o,
    input  logic                 release_valid_i,
    input  logic [ID_WIDTH-1:0]  release_id_i,
    input  logic                 flush_i,
    output logic [ID_WIDTH:0]    busy_cnt_o,
    output logic                 full_o,
    output logic                 empty_o,
    output logic                 err_o
);

    localparam int                CNT_W   = ID_WIDTH + 1;
    localparam logic [ID_WIDTH:0] C_RANGE = CNT_W'(RANGE);
    localparam logic [ID_WIDTH-1:0] C_LAST = ID_WIDTH'(RANGE - 1);

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [RANGE-1:0]       busy_q, busy_d;
    logic [ID_WIDTH-1:0]    prefer_q, prefer_d;
    logic                   grant_valid_q, grant_valid_d;
    logic [ID_WIDTH-1:0]    grant_id_q, grant_id_d;
    logic [TAG_WIDTH-1:0]   grant_tag_q, grant_tag_d;
    logic [ID_WIDTH:0]      busy_cnt_q, busy_cnt_d;
    logic                   err_q, err_d;

    // Ids at or above RANGE only exist for non-power-of-2 RANGE; they are
    // never indexed into the bitmap.
    logic w_sel_in_range, w_rel_in_range;
    logic w_sel_busy, w_rel_busy;
    logic w_run, w_hs, w_rel_ok, w_rel_bad, w_sel_err;

    always_comb begin
        w_sel_in_range = ({1'b0, sel_id_i} < C_RANGE);
        w_rel_in_range = ({1'b0, release_id_i} < C_RANGE);
        w_sel_busy     = w_sel_in_range && busy_q[sel_id_i];
        w_rel_busy     = w_rel_in_range && busy_q[release_id_i];
        w_run          = (state_q == ST_RUN) && !flush_i;
        alloc_ready_o  = w_run && sel_valid_i && w_sel_in_range && !w_sel_busy;
        w_hs           = alloc_valid_i && alloc_ready_o;
        w_rel_ok       = w_run && release_valid_i && w_rel_busy;
        // Covers both a free target and an out-of-range id.
        w_rel_bad      = w_run && release_valid_i && !w_rel_busy;
        // Selector claims a slot we already hold busy.
        w_sel_err      = sel_valid_i && w_sel_busy;
    end

    // Next-state FSM: flush_i always (re)enters FLUSH; otherwise back to RUN.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN:   state_d = flush_i ? ST_FLUSH : ST_RUN;
            ST_FLUSH: state_d = flush_i ? ST_FLUSH : ST_RUN;
            default:  state_d = ST_RUN;
        endcase
    end

    always_comb begin
        busy_d        = busy_q;
        prefer_d      = prefer_q;
        busy_cnt_d    = busy_cnt_q;
        grant_valid_d = w_hs;
        grant_id_d    = grant_id_q;
        grant_tag_d   = grant_tag_q;
        err_d         = err_q | w_rel_bad | w_sel_err;

        if (w_hs) begin
            grant_id_d  = sel_id_i;
            grant_tag_d = alloc_tag_i;
        end

        // Clearing on the flush request edge makes the FLUSH cycle already
        // show an empty bitmap; repeating it while in FLUSH is harmless.
        if (flush_i || (state_q == ST_FLUSH)) begin
            busy_d     = '0;
            busy_cnt_d = '0;
            prefer_d   = '0;
        end else begin
            if (w_hs) begin
                busy_d[sel_id_i] = 1'b1;
                prefer_d = (sel_id_i == C_LAST) ? '0 : sel_id_i + 1'b1;
            end
            // A valid release is never the handshake slot (busy vs. free).
            if (w_rel_ok) begin
                busy_d[release_id_i] = 1'b0;
            end
            busy_cnt_d = busy_cnt_q + CNT_W'(w_hs) - CNT_W'(w_rel_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            busy_q        <= '0;
            prefer_q      <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            grant_tag_q   <= '0;
            busy_cnt_q    <= '0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            busy_q        <= busy_d;
            prefer_q      <= prefer_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            grant_tag_q   <= grant_tag_d;
            busy_cnt_q    <= busy_cnt_d;
            err_q         <= err_d;
        end
    end

    always_comb begin
        avail_o       = ~busy_q;
        prefer_o      = prefer_q;
        grant_valid_o = grant_valid_q;
        grant_id_o    = grant_id_q;
        grant_tag_o   = grant_tag_q;
        busy_cnt_o    = busy_cnt_q;
        full_o        = (busy_cnt_q == C_RANGE);
        empty_o       = (busy_cnt_q == '0);
        err_o         = err_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_slot_alloc_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : tb_slot_alloc_tracker
//  Purpose  : Self-checking bench for slot_alloc_tracker. A slot-array model
//             predicts every output each cycle; directed scenarios pin the
//             model with literal values, then a randomized phase runs.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_slot_alloc_tracker;

    localparam int RANGE = 8;
    localparam int IDW   = 3;
    localparam int TAGW  = 4;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [RANGE-1:0]  avail_o;
    logic [IDW-1:0]    prefer_o;
    logic              sel_valid_i = 1'b0;
    logic [IDW-1:0]    sel_id_i = '0;
    logic              alloc_valid_i = 1'b0;
    logic [TAGW-1:0]   alloc_tag_i = '0;
    logic              alloc_ready_o;
    logic              grant_valid_o;
    logic [IDW-1:0]    grant_id_o;
    logic [TAGW-1:0]   grant_tag_o;
    logic              release_valid_i = 1'b0;
    logic [IDW-1:0]    release_id_i = '0;
    logic              flush_i = 1'b0;
    logic [IDW:0]      busy_cnt_o;
    logic              full_o;
    logic              empty_o;
    logic              err_o;

    slot_alloc_tracker #(.RANGE(RANGE), .ID_WIDTH(IDW), .TAG_WIDTH(TAGW)) dut (
        .clk(clk), .rst_n(rst_n),
        .avail_o(avail_o), .prefer_o(prefer_o),
        .sel_valid_i(sel_valid_i), .sel_id_i(sel_id_i),
        .alloc_valid_i(alloc_valid_i), .alloc_tag_i(alloc_tag_i),
        .alloc_ready_o(alloc_ready_o),
        .grant_valid_o(grant_valid_o), .grant_id_o(grant_id_o),
        .grant_tag_o(grant_tag_o),
        .release_valid_i(release_valid_i), .release_id_i(release_id_i),
        .flush_i(flush_i),
        .busy_cnt_o(busy_cnt_o), .full_o(full_o), .empty_o(empty_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit auto_sel = 1'b1;

    // ---------------- behavioural model ----------------
    bit m_busy[RANGE];
    int m_prefer;
    bit m_err;
    bit m_flushing;
    bit m_gv;
    int m_gid;
    int m_gtag;
    bit m_last_hs;

    function automatic int m_count();
        int n = 0;
        for (int i = 0; i < RANGE; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    function automatic logic [RANGE-1:0] m_avail();
        logic [RANGE-1:0] v;
        for (int i = 0; i < RANGE; i++) v[i] = !m_busy[i];
        return v;
    endfunction

    function automatic bit m_ready();
        return !m_flushing && !flush_i && sel_valid_i && !m_busy[int'(sel_id_i)];
    endfunction

    task automatic model_update();
        bit hs, run, relok, relbad;
        if (!rst_n) begin
            for (int i = 0; i < RANGE; i++) m_busy[i] = 1'b0;
            m_prefer = 0; m_err = 0; m_flushing = 0;
            m_gv = 0; m_gid = 0; m_gtag = 0; m_last_hs = 0;
        end else begin
            hs     = alloc_valid_i && m_ready();
            run    = !m_flushing && !flush_i;
            relok  = run && release_valid_i && m_busy[int'(release_id_i)];
            relbad = run && release_valid_i && !m_busy[int'(release_id_i)];
            if (relbad) m_err = 1;
            if (sel_valid_i && m_busy[int'(sel_id_i)]) m_err = 1;
            m_gv = hs;
            m_last_hs = hs;
            if (hs) begin
                m_gid  = int'(sel_id_i);
                m_gtag = int'(alloc_tag_i);
            end
            if (flush_i || m_flushing) begin
                for (int i = 0; i < RANGE; i++) m_busy[i] = 1'b0;
                m_prefer = 0;
            end else begin
                if (hs) begin
                    m_busy[int'(sel_id_i)] = 1'b1;
                    m_prefer = (int'(sel_id_i) + 1) % RANGE;
                end
                if (relok) m_busy[int'(release_id_i)] = 1'b0;
            end
            m_flushing = flush_i;
        end
    endtask

    // Preferred-first selector, driven from the model's view of the slots.
    task automatic drive_sel();
        if (auto_sel) begin
            sel_valid_i = 1'b0;
            sel_id_i    = '0;
            for (int k = 0; k < RANGE; k++) begin
                int j;
                j = (m_prefer + k) % RANGE;
                if (!sel_valid_i && !m_busy[j]) begin
                    sel_valid_i = 1'b1;
                    sel_id_i    = IDW'(j);
                end
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_all();
        int n;
        n = m_count();
        chk("avail",       64'(avail_o),       64'(m_avail()));
        chk("prefer",      64'(prefer_o),      64'(m_prefer));
        chk("alloc_ready", 64'(alloc_ready_o), 64'(m_ready()));
        chk("grant_valid", 64'(grant_valid_o), 64'(m_gv));
        chk("grant_id",    64'(grant_id_o),    64'(m_gid));
        chk("grant_tag",   64'(grant_tag_o),   64'(m_gtag));
        chk("busy_cnt",    64'(busy_cnt_o),    64'(n));
        chk("full",        64'(full_o),        64'(n == RANGE));
        chk("empty",       64'(empty_o),       64'(n == 0));
        chk("err",         64'(err_o),         64'(m_err));
    endtask

    // Inputs are set at the negedge; outputs compared 1ns later.
    task automatic prep();
        drive_sel();
        #1;
        check_all();
    endtask

    task automatic edge_step();
        @(posedge clk);
        model_update();
        @(negedge clk);
    endtask

    task automatic step();
        prep();
        edge_step();
    endtask

    initial begin
        @(negedge clk);
        rst_n = 1'b0;
        auto_sel = 1'b0;
        edge_step();
        edge_step();
        rst_n = 1'b1;

        // Reset values with no selector result.
        prep();
        chk("rst_avail", 64'(avail_o), 64'hFF);
        chk("rst_ready", 64'(alloc_ready_o), 64'h0);
        chk("rst_empty", 64'(empty_o), 64'h1);
        chk("rst_cnt",   64'(busy_cnt_o), 64'h0);
        edge_step();
        auto_sel = 1'b1;

        // Eight back-to-back allocations.
        alloc_valid_i = 1'b1;
        for (int i = 0; i < RANGE; i++) begin
            alloc_tag_i = TAGW'(i);
            step();
            chk("burst_gv",  64'(grant_valid_o), 64'h1);
            chk("burst_gid", 64'(grant_id_o), 64'(i));
            chk("burst_tag", 64'(grant_tag_o), 64'(i));
        end
        prep();
        chk("full_ready",  64'(alloc_ready_o), 64'h0);
        chk("full_full",   64'(full_o), 64'h1);
        chk("full_cnt",    64'(busy_cnt_o), 64'd8);
        chk("full_prefer", 64'(prefer_o), 64'h0);
        alloc_valid_i = 1'b0;
        edge_step();

        // Release 5 then reallocate it with tag 9.
        release_valid_i = 1'b1; release_id_i = 3'd5;
        step();
        release_valid_i = 1'b0;
        alloc_valid_i = 1'b1; alloc_tag_i = 4'd9;
        prep();
        chk("rel5_avail", 64'(avail_o), 64'h20);
        chk("rel5_ready", 64'(alloc_ready_o), 64'h1);
        edge_step();
        alloc_valid_i = 1'b0;
        prep();
        chk("re5_gv",     64'(grant_valid_o), 64'h1);
        chk("re5_gid",    64'(grant_id_o), 64'd5);
        chk("re5_tag",    64'(grant_tag_o), 64'd9);
        chk("re5_prefer", 64'(prefer_o), 64'd6);
        edge_step();

        // Free slot 3, then allocate it while releasing slot 1.
        release_valid_i = 1'b1; release_id_i = 3'd3;
        step();
        alloc_valid_i = 1'b1; alloc_tag_i = 4'd2; release_id_i = 3'd1;
        step();
        alloc_valid_i = 1'b0; release_valid_i = 1'b0;
        prep();
        chk("same_cnt",   64'(busy_cnt_o), 64'd7);
        chk("same_avail", 64'(avail_o), 64'h02);
        chk("same_gid",   64'(grant_id_o), 64'd3);
        chk("same_err",   64'(err_o), 64'h0);
        edge_step();

        // Release slot 2 twice: the second one targets a free slot.
        release_valid_i = 1'b1; release_id_i = 3'd2;
        step();
        step();
        release_valid_i = 1'b0;
        prep();
        chk("bad_err",   64'(err_o), 64'h1);
        chk("bad_cnt",   64'(busy_cnt_o), 64'd6);
        chk("bad_avail", 64'(avail_o), 64'h06);
        edge_step();

        // Bring down to 4 busy, then flush with a pending request.
        release_valid_i = 1'b1; release_id_i = 3'd0;
        step();
        release_id_i = 3'd3;
        step();
        release_valid_i = 1'b0;
        flush_i = 1'b1; alloc_valid_i = 1'b1; alloc_tag_i = 4'd7;
        prep();
        chk("fl_cnt4",  64'(busy_cnt_o), 64'd4);
        chk("fl_ready", 64'(alloc_ready_o), 64'h0);
        edge_step();
        flush_i = 1'b0;
        prep();
        chk("fl_gv",     64'(grant_valid_o), 64'h0);
        chk("fl_cnt",    64'(busy_cnt_o), 64'h0);
        chk("fl_prefer", 64'(prefer_o), 64'h0);
        chk("fl_empty",  64'(empty_o), 64'h1);
        chk("fl_ready0", 64'(alloc_ready_o), 64'h0);
        edge_step();
        step();
        chk("fl_resume_gv",  64'(grant_valid_o), 64'h1);
        chk("fl_resume_gid", 64'(grant_id_o), 64'h0);
        chk("fl_err_sticky", 64'(err_o), 64'h1);

        // Reset during a handshake.
        prep();
        chk("rstmid_ready", 64'(alloc_ready_o), 64'h1);
        rst_n = 1'b0;
        edge_step();
        rst_n = 1'b1; alloc_valid_i = 1'b0;
        prep();
        chk("rstmid_gv",    64'(grant_valid_o), 64'h0);
        chk("rstmid_avail", 64'(avail_o), 64'hFF);
        chk("rstmid_err",   64'(err_o), 64'h0);
        edge_step();

        // Selector reports a busy slot: not accepted, error raised.
        alloc_valid_i = 1'b1; alloc_tag_i = 4'd1;
        step();
        auto_sel = 1'b0; sel_valid_i = 1'b1; sel_id_i = 3'd0;
        prep();
        chk("incons_ready", 64'(alloc_ready_o), 64'h0);
        edge_step();
        alloc_valid_i = 1'b0; sel_valid_i = 1'b0;
        prep();
        chk("incons_err", 64'(err_o), 64'h1);
        chk("incons_gv",  64'(grant_valid_o), 64'h0);
        edge_step();
        auto_sel = 1'b1;

        // Randomized traffic.
        rst_n = 1'b0;
        edge_step();
        rst_n = 1'b1;
        alloc_valid_i = 1'b0;
        for (int c = 0; c < 3000; c++) begin
            rst_n   = ($urandom_range(0, 299) != 0);
            flush_i = ($urandom_range(0, 39) == 0);
            if (!alloc_valid_i || m_last_hs) begin
                alloc_valid_i = ($urandom_range(0, 2) != 0);
                alloc_tag_i   = TAGW'($urandom);
            end
            release_valid_i = ($urandom_range(0, 2) == 0);
            release_id_i    = IDW'($urandom);
            if ($urandom_range(0, 9) != 0) begin
                for (int k = 0; k < RANGE; k++) begin
                    int j;
                    j = (int'(release_id_i) + k) % RANGE;
                    if (m_busy[j]) begin
                        release_id_i = IDW'(j);
                        break;
                    end
                end
            end
            auto_sel = ($urandom_range(0, 49) != 0);
            if (!auto_sel) begin
                sel_valid_i = 1'($urandom);
                sel_id_i    = IDW'($urandom);
            end
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
